uart_rx_fifo: RTL

//  Receive-side FIFO for the UART; consumes the FCR controls (FIFOEN, RXCLR, RXFIFTL)
//  and buffers characters from the RX shifter until the host reads RBR.

---
 rtl/uart_pkg.sv | 31 +++
 rtl/uart_fifo_mem.sv | 31 +++
 rtl/uart_rx_fifo.sv | 103 ++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART constants: register addresses, RX trigger levels and FIFO sizing defaults.
package uart_pkg;

    localparam logic [7:0] FCR_ADDR   = 8'h08;

    localparam int UART_DEPTH = 16;
    localparam int UART_AW    = 4;

    localparam logic [1:0] RXFIFTL_1  = 2'b00;
    localparam logic [1:0] RXFIFTL_4  = 2'b01;
    localparam logic [1:0] RXFIFTL_8  = 2'b10;
    localparam logic [1:0] RXFIFTL_14 = 2'b11;

    localparam int TRIG_1  = 1;
    localparam int TRIG_4  = 4;
    localparam int TRIG_8  = 8;
    localparam int TRIG_14 = 14;

    function automatic int trig_level(input logic [1:0] sel);
        int lvl;
        lvl = TRIG_1;
        unique case (sel)
            RXFIFTL_1:  lvl = TRIG_1;
            RXFIFTL_4:  lvl = TRIG_4;
            RXFIFTL_8:  lvl = TRIG_8;
            RXFIFTL_14: lvl = TRIG_14;
        endcase
        return lvl;
    endfunction

endpackage

// File: rtl/uart_fifo_mem.sv
// RX FIFO storage: synchronous write, asynchronous (show-ahead) read.
// Entries reset to zero so the read port shows 0 straight out of reset.
module uart_fifo_mem
    import uart_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = UART_DEPTH,
    parameter int AW     = UART_AW
) (
    input  logic              m_clk,
    input  logic              reset,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge m_clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive FIFO: pointer/count control, FCR-driven clear, sticky overrun and
// RX trigger-level flag. Non-FIFO mode behaves as a single overwriting holding register.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = UART_DEPTH,
    parameter int AW     = UART_AW
) (
    input  logic              m_clk,
    input  logic              reset,
    input  logic              FIFOEN,
    input  logic              RXCLR,
    input  logic [1:0]        RXFIFTL,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic              ovr_clr,
    output logic [DATA_W-1:0] rd_data,
    output logic [AW:0]       count,
    output logic              empty,
    output logic              full,
    output logic              trigger_hit,
    output logic              overrun
);

    // wr_en/rd_en are single-cycle strobes with no back-pressure: a push into a full
    // FIFO is an overrun, a pop from an empty FIFO is ignored, and a clear event
    // in the same cycle swallows both.

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          rxclr_q;
    logic          fifoen_q;
    logic          clear;
    logic          push;
    logic          pop;
    logic          ovr_set;
    logic          ovw;
    logic          we;
    logic [AW-1:0] waddr;
    logic [AW:0]   trig_lvl;

    always_comb begin
        clear    = (RXCLR & ~rxclr_q) | (FIFOEN ^ fifoen_q);
        empty    = (count == '0);
        full     = FIFOEN ? (count == (AW+1)'(DEPTH)) : (count == (AW+1)'(1));
        pop      = rd_en & ~empty & ~clear;
        // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
        push     = wr_en & (~full | rd_en) & ~clear;
        ovr_set  = wr_en & full & ~rd_en & ~clear;
        // Holding-register mode replaces the single stored character in place.
        ovw      = ovr_set & ~FIFOEN;
        we       = push | ovw;
        waddr    = ovw ? rd_ptr : wr_ptr;
        trig_lvl = (AW+1)'(trig_level(RXFIFTL));
        trigger_hit = FIFOEN ? (count >= trig_lvl) : ~empty;
    end

    always_ff @(posedge m_clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overrun  <= 1'b0;
            rxclr_q  <= 1'b0;
            fifoen_q <= 1'b0;
        end else begin
            rxclr_q  <= RXCLR;
            fifoen_q <= FIFOEN;
            if (clear) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + AW'(1);
                if (pop)  rd_ptr <= rd_ptr + AW'(1);
                case ({push, pop})
                    2'b10:   count <= count + (AW+1)'(1);
                    2'b01:   count <= count - (AW+1)'(1);
                    default: count <= count;
                endcase
            end
            if (ovr_set)      overrun <= 1'b1;
            else if (ovr_clr) overrun <= 1'b0;
        end
    end

    uart_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_mem (
        .m_clk  (m_clk),
        .reset  (reset),
        .we     (we),
        .waddr  (waddr),
        .wdata  (wr_data),
        .raddr  (rd_ptr),
        .rdata  (rd_data)
    );

endmodule
